// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit and the
// pipeline registers that feed it.
package ex_muldiv_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_FREE_LIST_WIDTH = 3;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one result bit per cycle
// on operand magnitudes, with sign correction applied in a final FIX cycle.
//
// state  | meaning
// S_IDLE | waiting for a start; start is blocked by a same-cycle flush
// S_RUN  | DATA_WIDTH shift-add / restoring-divide iterations
// S_FIX  | sign-correct result, write HI/LO, pulse done
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int FREE_LIST_WIDTH = DEFAULT_FREE_LIST_WIDTH
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset_n,
  input  logic                       i_Flush,
  input  logic                       i_Start,
  input  logic [1:0]                 i_Op,
  input  logic [DATA_WIDTH-1:0]      i_Operand1,
  input  logic [DATA_WIDTH-1:0]      i_Operand2,
  input  logic [FREE_LIST_WIDTH-1:0] i_Phys_Active_List_Index,
  output logic                       o_Busy,
  output logic                       o_Done,
  output logic [FREE_LIST_WIDTH-1:0] o_Phys_Active_List_Index,
  output logic [DATA_WIDTH-1:0]      o_HI,
  output logic [DATA_WIDTH-1:0]      o_LO
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  function automatic logic [DATA_WIDTH-1:0] neg_if(input logic flag,
                                                  input logic [DATA_WIDTH-1:0] v);
    return flag ? -v : v;
  endfunction

  state_e                      state, state_nxt;
  logic [CNT_W-1:0]            count;
  logic                        is_div;
  logic                        neg_q, neg_r;
  logic [FREE_LIST_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0]       opnd_a;   // multiplicand / divisor magnitude
  logic [DATA_WIDTH-1:0]       opnd_b;   // multiplier (shifts out) / dividend->quotient
  logic [2*DATA_WIDTH-1:0]     acc;
  logic [DATA_WIDTH-1:0]       rem;

  logic                        start_ok;
  logic                        in_signed, in_div;
  logic                        sign1, sign2;
  logic [DATA_WIDTH-1:0]       abs1, abs2;
  logic [DATA_WIDTH:0]         mul_sum;
  logic [DATA_WIDTH:0]         div_shift, div_diff;
  logic [2*DATA_WIDTH-1:0]     prod_fix;

  assign start_ok  = (state == S_IDLE) && i_Start && !i_Flush;
  assign in_signed = (op_e'(i_Op) == OP_MULT) || (op_e'(i_Op) == OP_DIV);
  assign in_div    = (op_e'(i_Op) == OP_DIV)  || (op_e'(i_Op) == OP_DIVU);
  assign sign1     = in_signed & i_Operand1[DATA_WIDTH-1];
  assign sign2     = in_signed & i_Operand2[DATA_WIDTH-1];
  assign abs1      = neg_if(sign1, i_Operand1);
  assign abs2      = neg_if(sign2, i_Operand2);

  assign mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + {1'b0, (opnd_b[0] ? opnd_a : {DATA_WIDTH{1'b0}})};
  assign div_shift = {rem, opnd_b[DATA_WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_a};
  assign prod_fix  = neg_q ? -acc : acc;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_Busy    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_RUN;
          o_Busy    = 1'b1;
        end
      end
      S_RUN: begin
        o_Busy = 1'b1;
        if (i_Flush)           state_nxt = S_IDLE;
        else if (count == '0)  state_nxt = S_FIX;
      end
      S_FIX: begin
        o_Busy    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count                    <= '0;
      is_div                   <= 1'b0;
      neg_q                    <= 1'b0;
      neg_r                    <= 1'b0;
      tag                      <= '0;
      opnd_a                   <= '0;
      opnd_b                   <= '0;
      acc                      <= '0;
      rem                      <= '0;
      o_Done                   <= 1'b0;
      o_Phys_Active_List_Index <= '0;
      o_HI                     <= '0;
      o_LO                     <= '0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            is_div <= in_div;
            tag    <= i_Phys_Active_List_Index;
            opnd_a <= in_div ? abs2 : abs1;
            opnd_b <= in_div ? abs1 : abs2;
            neg_q  <= sign1 ^ sign2;
            neg_r  <= sign1;
            acc    <= '0;
            rem    <= '0;
            count  <= CNT_W'(DATA_WIDTH - 1);
          end
        end
        S_RUN: begin
          if (!i_Flush) begin
            count <= count - 1'b1;
            if (is_div) begin
              // restoring step: keep the subtraction only if it did not borrow
              if (!div_diff[DATA_WIDTH]) begin
                rem    <= div_diff[DATA_WIDTH-1:0];
                opnd_b <= {opnd_b[DATA_WIDTH-2:0], 1'b1};
              end else begin
                rem    <= div_shift[DATA_WIDTH-1:0];
                opnd_b <= {opnd_b[DATA_WIDTH-2:0], 1'b0};
              end
            end else begin
              acc    <= {mul_sum, acc[DATA_WIDTH-1:1]};
              opnd_b <= opnd_b >> 1;
            end
          end
        end
        S_FIX: begin
          if (!i_Flush) begin
            if (is_div) begin
              o_LO <= neg_if(neg_q, opnd_b);
              o_HI <= neg_if(neg_r, rem);
            end else begin
              o_HI <= prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
              o_LO <= prod_fix[DATA_WIDTH-1:0];
            end
            o_Done                   <= 1'b1;
            o_Phys_Active_List_Index <= tag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and randomized checks of ex_muldiv against an arithmetic model of
// MULT/MULTU/DIV/DIVU, including latency, stall, flush and reset behaviour.
module tb_ex_muldiv;

  logic        i_Clk = 1'b0;
  logic        i_Reset_n;
  logic        i_Flush;
  logic        i_Start;
  logic [1:0]  i_Op;
  logic [31:0] i_Operand1, i_Operand2;
  logic [2:0]  i_Phys_Active_List_Index;
  logic        o_Busy, o_Done;
  logic [2:0]  o_Phys_Active_List_Index;
  logic [31:0] o_HI, o_LO;

  int vectors = 0;
  int errs    = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  ex_muldiv dut (
    .i_Clk                    (i_Clk),
    .i_Reset_n                (i_Reset_n),
    .i_Flush                  (i_Flush),
    .i_Start                  (i_Start),
    .i_Op                     (i_Op),
    .i_Operand1               (i_Operand1),
    .i_Operand2               (i_Operand2),
    .i_Phys_Active_List_Index (i_Phys_Active_List_Index),
    .o_Busy                   (o_Busy),
    .o_Done                   (o_Done),
    .o_Phys_Active_List_Index (o_Phys_Active_List_Index),
    .o_HI                     (o_HI),
    .o_LO                     (o_LO)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference arithmetic: full-width products, and /,% on magnitudes with
  // divide-by-zero defined as quotient all-ones, remainder = dividend.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa64, sb64, sp;
    logic [63:0] up;
    logic [31:0] ma, mb, q, r;
    logic sa, sb;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sp = sa64 * sb64;
        {hi, lo} = sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      default: begin
        sa = (op == 2'b10) && a[31];
        sb = (op == 2'b10) && b[31];
        ma = sa ? (32'd0 - a) : a;
        mb = sb ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = ma;
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        lo = (sa ^ sb) ? (32'd0 - q) : q;
        hi = sa ? (32'd0 - r) : r;
      end
    endcase
  endfunction

  // Called about 1 time unit after a rising edge; returns in the done cycle.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] tag);
    int cyc, busy_cnt;
    bit got;
    model(op, a, b, exp_hi, exp_lo);
    i_Start = 1'b1;
    i_Op = op;
    i_Operand1 = a;
    i_Operand2 = b;
    i_Phys_Active_List_Index = tag;
    #1;
    check({name, ".busy_start"}, 64'(o_Busy), 64'd1);
    busy_cnt = o_Busy ? 1 : 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge i_Clk);
      #1;
      if (cyc == 0) i_Start = 1'b0;
      cyc++;
      if (o_Done) got = 1'b1;
      else if (o_Busy) busy_cnt++;
    end
    check({name, ".latency"}, 64'(cyc), 64'd34);
    check({name, ".busy_cycles"}, 64'(busy_cnt), 64'd34);
    check({name, ".busy_at_done"}, 64'(o_Busy), 64'd0);
    check({name, ".hi"}, 64'(o_HI), 64'(exp_hi));
    check({name, ".lo"}, 64'(o_LO), 64'(exp_lo));
    check({name, ".tag"}, 64'(o_Phys_Active_List_Index), 64'(tag));
  endtask

  task automatic idle_cycle(input string name);
    @(posedge i_Clk);
    #1;
    check({name, ".done_low"}, 64'(o_Done), 64'd0);
  endtask

  task automatic no_done_window(input string name, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge i_Clk);
      #1;
      if (o_Done) seen = 1'b1;
    end
    check({name, ".no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    i_Reset_n = 1'b0;
    i_Flush = 1'b0;
    i_Start = 1'b0;
    i_Op = 2'b00;
    i_Operand1 = '0;
    i_Operand2 = '0;
    i_Phys_Active_List_Index = '0;
    #12;
    check("rst.busy", 64'(o_Busy), 64'd0);
    check("rst.done", 64'(o_Done), 64'd0);
    check("rst.hi", 64'(o_HI), 64'd0);
    check("rst.lo", 64'(o_LO), 64'd0);
    check("rst.tag", 64'(o_Phys_Active_List_Index), 64'd0);
    @(posedge i_Clk);
    #1;
    i_Reset_n = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2);
    check("multu_max.hi_const", 64'(o_HI), 64'hFFFF_FFFE);
    check("multu_max.lo_const", 64'(o_LO), 64'h0000_0001);
    idle_cycle("multu_max");

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 3'd5);
    check("mult_neg.lo_const", 64'(o_LO), 64'hFFFF_FFEB);
    idle_cycle("mult_neg");

    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 3'd1);
    check("div_neg.lo_const", 64'(o_LO), 64'hFFFF_FFFD);
    check("div_neg.hi_const", 64'(o_HI), 64'hFFFF_FFFF);
    run_op("divu_b2b", 2'b11, 32'd100, 32'd7, 3'd6);
    check("divu_b2b.lo_const", 64'(o_LO), 64'd14);
    check("divu_b2b.hi_const", 64'(o_HI), 64'd2);
    idle_cycle("divu_b2b");

    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 3'd3);
    check("divu_zero.lo_const", 64'(o_LO), 64'hFFFF_FFFF);
    check("divu_zero.hi_const", 64'(o_HI), 64'd7);
    idle_cycle("divu_zero");
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 3'd4);
    check("div_ovf.lo_const", 64'(o_LO), 64'h8000_0000);
    check("div_ovf.hi_const", 64'(o_HI), 64'd0);
    idle_cycle("div_ovf");
    run_op("div_neg_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 3'd7);
    idle_cycle("div_neg_zero");

    // Flush in the tenth RUN cycle.
    i_Start = 1'b1;
    i_Op = 2'b01;
    i_Operand1 = 32'd3;
    i_Operand2 = 32'd4;
    i_Phys_Active_List_Index = 3'd2;
    @(posedge i_Clk);
    #1;
    i_Start = 1'b0;
    repeat (9) @(posedge i_Clk);
    #1;
    i_Flush = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Flush = 1'b0;
    check("flush.busy_after", 64'(o_Busy), 64'd0);
    check("flush.done", 64'(o_Done), 64'd0);
    no_done_window("flush", 40);
    check("flush.hi_kept", 64'(o_HI), 64'(exp_hi));
    check("flush.lo_kept", 64'(o_LO), 64'(exp_lo));

    // Start and flush together in IDLE: nothing starts.
    i_Start = 1'b1;
    i_Flush = 1'b1;
    #1;
    check("idle_flush.busy", 64'(o_Busy), 64'd0);
    @(posedge i_Clk);
    #1;
    i_Start = 1'b0;
    i_Flush = 1'b0;
    check("idle_flush.busy_next", 64'(o_Busy), 64'd0);
    no_done_window("idle_flush", 40);

    run_op("after_flush", 2'b01, 32'd3, 32'd4, 3'd6);
    idle_cycle("after_flush");

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'd0;
        default: rb = 32'd0 - 32'($urandom_range(1, 15));
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 0) idle_cycle($sformatf("rand%0d", i));
    end
    idle_cycle("rand_end");

    // Asynchronous reset in the middle of RUN.
    i_Start = 1'b1;
    i_Op = 2'b01;
    i_Operand1 = 32'h1234_5678;
    i_Operand2 = 32'h9ABC_DEF0;
    i_Phys_Active_List_Index = 3'd3;
    @(posedge i_Clk);
    #1;
    i_Start = 1'b0;
    repeat (12) @(posedge i_Clk);
    #3;
    i_Reset_n = 1'b0;
    #1;
    check("arst.busy", 64'(o_Busy), 64'd0);
    check("arst.hi", 64'(o_HI), 64'd0);
    check("arst.lo", 64'(o_LO), 64'd0);
    check("arst.done", 64'(o_Done), 64'd0);
    #3;
    i_Reset_n = 1'b1;
    no_done_window("arst", 40);
    check("arst.hi_after", 64'(o_HI), 64'd0);
    check("arst.busy_after", 64'(o_Busy), 64'd0);

    run_op("after_rst", 2'b00, 32'h8000_0000, 32'h8000_0000, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the execute stage, fed by the decode/execute pipeline register alongside the ALU. It accepts one MULT/MULTU/DIV/DIVU operation at a time and computes it over DATA_WIDTH+1 cycles. While the operation runs it asserts a stall request that holds the pipeline front end. It owns the architectural HI/LO registers read by MFHI/MFLO.

## Interface
- DATA_WIDTH, 32: operand width and HI/LO width.
- FREE_LIST_WIDTH, 3: width of the active-list tag carried with the operation.
- i_Clk  in  1  clock; all state changes on the rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Flush  in  1  aborts any in-flight operation; blocks a start in the same cycle.
- i_Start  in  1  operation request; valid only while the dec/ex register holds a mul/div instruction.
- i_Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_Operand1  in  DATA_WIDTH  multiplicand / dividend (rs).
- i_Operand2  in  DATA_WIDTH  multiplier / divisor (rt).
- i_Phys_Active_List_Index  in  FREE_LIST_WIDTH  commit tag of the operation.
- o_Busy  out  1  stall request (combinational).
- o_Done  out  1  one-cycle completion pulse (registered).
- o_Phys_Active_List_Index  out  FREE_LIST_WIDTH  tag of the completed operation; valid with o_Done.
- o_HI  out  DATA_WIDTH  HI register.
- o_LO  out  DATA_WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - If i_Start & !i_Flush: latch the op, the tag and the absolute-value operands.
  - Signed ops use two's-complement magnitude. Unsigned ops pass operands unchanged.
  - Record the result sign flags: quotient/product negative = sign1 ^ sign2; remainder negative = sign1.
  - Clear the accumulator, load count = DATA_WIDTH-1, then go to RUN.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2*DATA_WIDTH accumulator.
- RUN, divide: restoring divide, one quotient bit per cycle, MSB first, with a DATA_WIDTH+1 bit partial remainder.
- RUN exit: when count reaches 0, go to FIX. The count decrements each RUN cycle.
- FIX:
  - Apply sign correction (negate the product, quotient and/or remainder per the flags).
  - Write HI/LO: multiply gives HI = product[2W-1:W], LO = product[W-1:0]; divide gives LO = quotient, HI = remainder.
  - Register o_Done = 1 and drive o_Phys_Active_List_Index = latched tag, then go to IDLE.
- Divide by zero needs no special path; the datapath naturally yields magnitude quotient all-ones and remainder = dividend magnitude. After sign fix:
  - DIVU x/0: LO = 0xFFFFFFFF, HI = x.
  - DIV by zero: same rule, with sign correction applied.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No exception.
- o_Busy = (IDLE & i_Start & !i_Flush) | RUN | FIX.
- Flush in RUN or FIX: return to IDLE next edge. HI/LO unchanged, no o_Done, tag discarded.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - o_HI, o_LO, o_Done, o_Phys_Active_List_Index and all internal datapath registers go to 0.

## Timing
- Start accepted at edge E0.
- RUN occupies edges E1..E32 (DATA_WIDTH edges). FIX executes at edge E33.
- HI/LO are updated and o_Done is high in the cycle following E33, i.e. 34 cycles after the start cycle.
- o_Busy is high from the start cycle through the FIX cycle, and low in the o_Done cycle. This lets the dec/ex register advance exactly once.
- A new start is legal in the o_Done cycle (back-to-back). In that case o_Busy goes high again combinationally.
- o_Done is never high for two consecutive cycles.
- o_HI/o_LO are stable outside the o_Done edge. A read in the o_Done cycle sees the new values.
- i_Start while in RUN/FIX is ignored. The stall guarantees it is held until IDLE.
- i_Flush and i_Start together in IDLE: no start, o_Busy = 0.

## Structure
- Shared package holds:
  - the op encodings (MULT/MULTU/DIV/DIVU);
  - the state encoding;
  - DATA_WIDTH / FREE_LIST_WIDTH defaults, shared with the pipeline registers.
- Counter width = clog2(DATA_WIDTH), derived locally.
- Single module, no sub-module. Optional: a small combinational helper for negate-if-flag, used for operand abs and result fix.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; o_Done exactly 34 cycles after the start cycle; o_Busy high for exactly 34 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; tag 5 returned on o_Phys_Active_List_Index with o_Done.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then, started in the o_Done cycle, DIVU 100 / 7 -> LO = 14, HI = 2.
- DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7. Then DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Start MULTU 3 × 4, assert i_Flush on RUN cycle 10 -> no o_Done; HI/LO keep their prior values; o_Busy low next cycle. A following start completes normally.
- Deassert i_Reset_n mid-RUN, asynchronously -> o_Busy low immediately (no i_Start applied); HI = LO = 0; no o_Done after reset release.
